// File: rtl/peak_meter_pkg.sv
// peak_meter_pkg: state encoding and counter sizing shared by the peak meter.
package peak_meter_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, DECAY} peak_state_t;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/peak_meter_abs_sat.sv
// abs_sat: signed W-bit sample to unsigned W-1-bit magnitude, most negative value saturates.
module abs_sat #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  output logic [W-2:0] mag_o
);
  logic [W-1:0] neg;
  assign neg = -a_i;
  assign mag_o = !a_i[W-1] ? a_i[W-2:0] : neg[W-1] ? '1 : neg[W-2:0];
endmodule

// File: rtl/peak_meter.sv
// peak_meter: peak-hold level meter with geometric decay.
// Optional full-scale clip detector enabled by defining PEAK_METER_CLIP_EN.
module peak_meter
  import peak_meter_pkg::*;
#(
  parameter int W            = 16,
  parameter int HOLD_SAMPLES = 4800,
  parameter int DECAY_SHIFT  = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample_valid,
  input  logic [W-1:0] sample_in,
  output logic [W-2:0] level_out,
  output logic         level_valid,
  output logic         clip
);
  localparam int LW = W - 1;
  localparam int CW = cnt_w(HOLD_SAMPLES);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_SAMPLES - 1);
  peak_state_t state_q, state_d;
  logic [LW-1:0] level_q, level_d, mag, shifted, step, decayed;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic valid_q;
  abs_sat #(.W(W)) u_abs (.a_i(sample_in), .mag_o(mag));
  assign shifted = level_q >> DECAY_SHIFT;
  assign step = (shifted == '0) ? LW'(1) : shifted;
  assign decayed = level_q - step;
  // A zero sample at level 0 is not a peak, so silence keeps the meter in IDLE.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_cnt_d = hold_cnt_q;
    if (sample_valid) begin
      if (mag >= level_q && mag != '0) begin
        level_d = mag;
        hold_cnt_d = RELOAD;
        state_d = HOLD;
      end else if (state_q == HOLD && hold_cnt_q != '0) begin
        hold_cnt_d = hold_cnt_q - CW'(1);
      end else if (state_q != IDLE) begin
        level_d = decayed;
        state_d = (decayed == '0) ? IDLE : DECAY;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      hold_cnt_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      hold_cnt_q <= hold_cnt_d;
      valid_q <= sample_valid;
    end
  end
  assign level_out = level_q;
  assign level_valid = valid_q;
`ifdef PEAK_METER_CLIP_EN
  logic [CW-1:0] clip_cnt_q, clip_cnt_d;
  logic clip_q, clip_d, full;
  assign full = (sample_in == {1'b0, {LW{1'b1}}}) || (sample_in == {1'b1, {LW{1'b0}}});
  always_comb begin
    clip_d = clip_q;
    clip_cnt_d = clip_cnt_q;
    if (sample_valid) begin
      clip_d = full || clip_cnt_q != '0;
      clip_cnt_d = full ? RELOAD : (clip_cnt_q != '0) ? clip_cnt_q - CW'(1) : clip_cnt_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_q <= 1'b0;
      clip_cnt_q <= '0;
    end else begin
      clip_q <= clip_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end
  assign clip = clip_q;
`else
  assign clip = 1'b0;
`endif
endmodule
